// File: rtl/lcd1604_bus_responder_pkg.sv
// rtl/lcd1604_bus_responder_pkg.sv - shared types, constants and DDRAM address helpers
package lcd1604_bus_responder_pkg;

  typedef enum logic [1:0] {ST_FILL, ST_BUSY, ST_IDLE, ST_DECODE} state_t;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [6:0] ROW0_BASE  = 7'h00;
  localparam logic [6:0] ROW0_LAST  = 7'h27;
  localparam logic [6:0] ROW1_BASE  = 7'h40;
  localparam logic [6:0] ROW1_LAST  = 7'h67;
  localparam logic [5:0] FILL_LAST  = 6'd63;

  // DDRAM is two disjoint 40-byte lines; stepping wraps between them.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == ROW0_LAST) return ROW1_BASE;
      else if (a == ROW1_LAST) return ROW0_BASE;
      else return a + 7'd1;
    end else begin
      if (a == ROW0_BASE) return ROW1_LAST;
      else if (a == ROW1_BASE) return ROW0_LAST;
      else return a - 7'd1;
    end
  endfunction

  function automatic logic ddram_valid(input logic [6:0] a);
    return (a <= ROW0_LAST) || ((a >= ROW1_BASE) && (a <= ROW1_LAST));
  endfunction

endpackage

// File: rtl/lcd1604_bus_responder_if.sv
// rtl/lcd1604_bus_responder_if.sv - HD44780 8-bit parallel bus (RS/RW/E/D) with read-back path
interface lcd1604_bus_responder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;

  modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data, input lcd_data_o, lcd_data_oe);
  modport slave  (input lcd_rs, lcd_rw, lcd_e, lcd_data, output lcd_data_o, lcd_data_oe);
endinterface

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - multi-stage synchronizer for {e,rs,rw,data} plus E falling-edge pulse
module lcd_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_in,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  output logic       e_s,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] data_s,
  output logic       e_fall
);
  logic [10:0] pipe [STAGES];
  logic        e_d;

  // All bus bits travel together so rs/rw/data line up with the synced E edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      e_d <= 1'b0;
    end else begin
      pipe[0] <= {e_in, rs_in, rw_in, data_in};
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      e_d <= pipe[STAGES-1][10];
    end
  end

  assign {e_s, rs_s, rw_s, data_s} = pipe[STAGES-1];
  assign e_fall = e_d & ~e_s;
endmodule

// File: rtl/lcd1604_bus_responder.sv
// rtl/lcd1604_bus_responder.sv - HD44780 display-side responder with DDRAM shadow and busy emulation
// Optional read-back support (rw=1) is enabled by defining LCD_RESP_READ_EN.
module lcd1604_bus_responder
  import lcd1604_bus_responder_pkg::*;
#(
  parameter int BUSY_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  lcd1604_bus_responder_if.slave      bus,
  output logic                        busy_o,
  output logic [6:0]                  cursor_o,
  output logic [2:0]                  disp_ctrl_o,
  input  logic [5:0]                  rd_addr,
  output logic [7:0]                  rd_char,
  output logic                        err_o
);
  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

  state_t      state, state_d;
  logic [5:0]  idx;
  logic [15:0] cnt;
  logic [6:0]  cursor;
  logic        id_inc, cgram_mode;
  logic        cmd_rs;
  logic [7:0]  cmd_data;
  logic        e_s, rs_s, rw_s, e_fall;
  logic [7:0]  data_s;
  logic        accept, busy_err, is_clear, is_home;
  logic        wr_en;
  logic [5:0]  wr_idx, cur_idx;
  logic [7:0]  wr_data;
  logic [7:0]  shadow [64];

  lcd_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .e_in    (bus.lcd_e),
    .rs_in   (bus.lcd_rs),
    .rw_in   (bus.lcd_rw),
    .data_in (bus.lcd_data),
    .e_s     (e_s),
    .rs_s    (rs_s),
    .rw_s    (rw_s),
    .data_s  (data_s),
    .e_fall  (e_fall)
  );

  assign cur_idx  = {cursor[4], cursor[6], cursor[3:0]};
  assign accept   = e_fall & ~rw_s & (state == ST_IDLE);
  assign busy_err = e_fall & ~rw_s & (state != ST_IDLE);
  assign is_clear = ~cmd_rs & (cmd_data == OP_CLEAR);
  assign is_home  = ~cmd_rs & (cmd_data[7:1] == 7'b0000001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FILL;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy_o  = (state != ST_IDLE);
    wr_en   = 1'b0;
    wr_idx  = cur_idx;
    wr_data = cmd_data;
    case (state)
      ST_FILL: begin
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = BLANK_CHAR;
        if (idx == FILL_LAST) state_d = ST_BUSY;
      end
      ST_BUSY:   if (cnt == '0) state_d = ST_IDLE;
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: begin
        wr_en   = cmd_rs & ~cgram_mode & ~cursor[5];
        state_d = is_clear ? ST_FILL : ST_BUSY;
      end
      default:   state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      cnt        <= '0;
      cursor     <= '0;
      id_inc     <= 1'b1;
      disp_ctrl_o <= '0;
      cgram_mode <= 1'b0;
      err_o      <= 1'b0;
      cmd_rs     <= 1'b0;
      cmd_data   <= '0;
    end else begin
      if (busy_err) err_o <= 1'b1;
      case (state)
        ST_FILL: begin
          idx <= idx + 6'd1;
          if (idx == FILL_LAST) cnt <= CLEAR_LOAD;
        end
        ST_BUSY: cnt <= cnt - 16'd1;
        ST_IDLE: begin
          if (accept) begin
            cmd_rs   <= rs_s;
            cmd_data <= data_s;
          end
`ifdef LCD_RESP_READ_EN
          else if (e_fall & rw_s & rs_s) cursor <= step_addr(cursor, id_inc);
`endif
        end
        ST_DECODE: begin
          idx <= '0;
          cnt <= is_home ? CLEAR_LOAD : BUSY_LOAD;
          if (cmd_rs) begin
            if (!cgram_mode) cursor <= step_addr(cursor, id_inc);
          end else begin
            casez (cmd_data)
              8'b1???????: begin
                cgram_mode <= 1'b0;
                if (ddram_valid(cmd_data[6:0])) cursor <= cmd_data[6:0];
                else err_o <= 1'b1;
              end
              8'b01??????: cgram_mode <= 1'b1;
              8'b001?????: if (!cmd_data[4]) err_o <= 1'b1;
              8'b0001????: if (!cmd_data[3]) cursor <= step_addr(cursor, cmd_data[2]);
              8'b00001???: disp_ctrl_o <= cmd_data[2:0];
              8'b000001??: id_inc <= cmd_data[1];
              8'b0000001?: cursor <= '0;
              8'b00000001: begin
                cursor <= '0;
                id_inc <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) shadow[wr_idx] <= wr_data;
  end

  assign rd_char  = shadow[rd_addr];
  assign cursor_o = cursor;

`ifdef LCD_RESP_READ_EN
  assign bus.lcd_data_oe = e_s & rw_s;
  assign bus.lcd_data_o  = rs_s ? (cursor[5] ? BLANK_CHAR : shadow[cur_idx]) : {busy_o, cursor};
`else
  logic unused_sync_e;
  assign unused_sync_e   = e_s;
  assign bus.lcd_data_oe = 1'b0;
  assign bus.lcd_data_o  = 8'h00;
`endif
endmodule

// File: tb/tb_lcd1604_bus_responder.sv
// tb/tb_lcd1604_bus_responder.sv - directed self-checking bench for lcd1604_bus_responder
module tb_lcd1604_bus_responder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy_o, err_o;
  logic [6:0] cursor_o;
  logic [2:0] disp_ctrl_o;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_char;
  int         n_tests = 0;
  int         n_fail = 0;

  lcd1604_bus_responder_if bus ();

  lcd1604_bus_responder #(.BUSY_CYCLES(8), .CLEAR_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy_o      (busy_o),
    .cursor_o    (cursor_o),
    .disp_ctrl_o (disp_ctrl_o),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_char(input string tag, input int idx, input logic [7:0] exp);
    rd_addr = 6'(idx);
    #1;
    check(tag, rd_char, exp);
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_e = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    repeat (5) @(negedge clk);
    while (busy_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("busy_timeout", busy_o, 1'b0);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    strobe(rs, 1'b0, d);
    wait_ready();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.lcd_e = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b1);
    reset = 1'b1;
    wait_ready();
  endtask

  initial begin
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cursor", cursor_o, 7'h00);
    check("rst_disp", disp_ctrl_o, 3'b000);
    check("rst_err", err_o, 1'b0);
    check("rst_oe", bus.lcd_data_oe, 1'b0);
    check("rst_dout", bus.lcd_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b1);
    reset = 1'b1;
    repeat (79) @(posedge clk);
    #1 check("busy_fill_clear", busy_o, 1'b1);
    @(posedge clk);
    #1 check("busy_release", busy_o, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk_char($sformatf("blank_%0d", i), i, 8'h20);

    wr(0, 8'h38); wr(0, 8'h0C); wr(0, 8'h06); wr(1, 8'h48); wr(1, 8'h49);
    chk_char("char0", 0, 8'h48);
    chk_char("char1", 1, 8'h49);
    check("cursor_after_hi", cursor_o, 7'h02);
    check("disp_ctrl", disp_ctrl_o, 3'b100);
    check("err_clean", err_o, 1'b0);

    wr(0, 8'hC0); wr(1, 8'h41); chk_char("row1", 16, 8'h41);
    wr(0, 8'h90); wr(1, 8'h42); chk_char("row2", 32, 8'h42);
    wr(0, 8'hD0); wr(1, 8'h43); chk_char("row3", 48, 8'h43);
    check("cursor_row3", cursor_o, 7'h51);

    wr(0, 8'hA7); wr(1, 8'h5A);
    check("wrap_27_40", cursor_o, 7'h40);
    chk_char("no_write_hidden", 7, 8'h20);
    chk_char("row1_kept", 16, 8'h41);

    wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h44);
    check("wrap_00_67", cursor_o, 7'h67);
    chk_char("dec_write", 0, 8'h44);
    wr(0, 8'h14); check("shift_right_wrap", cursor_o, 7'h00);
    wr(0, 8'h10); check("shift_left_wrap", cursor_o, 7'h67);

    wr(0, 8'h01);
    check("clear_cursor", cursor_o, 7'h00);
    chk_char("clear_char0", 0, 8'h20);
    chk_char("clear_char48", 48, 8'h20);
    wr(1, 8'h30);
    check("clear_id_inc", cursor_o, 7'h01);
    chk_char("post_clear_wr", 0, 8'h30);

    strobe(1, 0, 8'h31);
    repeat (2) @(negedge clk);
    strobe(1, 0, 8'h55);
    wait_ready();
    check("busy_strobe_err", err_o, 1'b1);
    check("busy_strobe_cursor", cursor_o, 7'h02);
    chk_char("accepted_wr", 1, 8'h31);
    chk_char("dropped_wr", 2, 8'h20);
    wr(0, 8'h02);
    check("home_cursor", cursor_o, 7'h00);

    do_reset();
    wr(0, 8'hA8);
    check("bad_ddram_err", err_o, 1'b1);
    check("bad_ddram_cursor", cursor_o, 7'h00);

    do_reset();
    wr(0, 8'h28);
    check("func_4bit_err", err_o, 1'b1);

    do_reset();
    wr(0, 8'h40); wr(1, 8'h77);
    check("cgram_cursor", cursor_o, 7'h00);
    chk_char("cgram_drop", 0, 8'h20);
    wr(0, 8'h80); wr(1, 8'h78);
    chk_char("ddram_back", 0, 8'h78);
    check("ddram_back_cursor", cursor_o, 7'h01);
    check("cgram_err", err_o, 1'b0);

`ifdef LCD_RESP_READ_EN
    strobe(1, 0, 8'h61);
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b1; bus.lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_busy_oe", bus.lcd_data_oe, 1'b1);
    check("rd_busy_data", bus.lcd_data_o, 8'h82);
    bus.lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_oe_drop", bus.lcd_data_oe, 1'b0);
    wait_ready();
    check("rd_busy_no_err", err_o, 1'b0);
    wr(0, 8'h80);
    @(negedge clk);
    bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b1; bus.lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_char_data", bus.lcd_data_o, 8'h78);
    bus.lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_char_step", cursor_o, 7'h01);
`else
    strobe(1, 1, 8'h99);
    repeat (6) @(negedge clk);
    check("rd_ignored_oe", bus.lcd_data_oe, 1'b0);
    check("rd_ignored_data", bus.lcd_data_o, 8'h00);
    check("rd_ignored_cursor", cursor_o, 7'h01);
    check("rd_ignored_err", err_o, 1'b0);
    check("rd_ignored_busy", busy_o, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
